// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, fixed-latency synchronous RAM
// between the instruction-fetch port and the load/store data port.
// Each access runs IDLE -> ACCESS -> WAIT -> RESP. A misaligned or
// reserved-size data request goes IDLE -> RESP and never touches memory.
// Byte enables and write-data lane replication are produced on the way out.
// Load data is lane-selected and extended on the way back.
// Optional macro ARB_RR_EN: when it is defined, round-robin arbitration is
// used when both ports request together. When it is not defined, the data
// port always wins.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  // load/store port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_sext,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  // memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // The wait counter starts at MEM_LAT-1. It counts down to zero in WAIT.
  localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;     // 1 = data port, 0 = fetch port
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic              err_q, err_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              prefer_data;
  logic              win_data;
  logic              win_fetch;
  logic              is_idle;
  logic              d_misalign;
  logic [3:0]        be_w;
  logic [31:0]       wdata_w;
  logic [31:0]       lane_shift;
  logic [31:0]       load_w;

`ifdef ARB_RR_EN
  // rr_q = 1 means the data port wins the next tie.
  logic rr_q, rr_d;

  // Round-robin pointer: the port just granted loses the next tie.
  always_comb begin
    rr_d = rr_q;
    if (is_idle && (win_data || win_fetch)) begin
      rr_d = ~win_data;
    end
  end

  // Pointer register. It favours the data port out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q <= 1'b1;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign prefer_data = rr_q;
`else
  assign prefer_data = 1'b1;
`endif

  // Arbitration and request legality. Requests only matter while IDLE.
  always_comb begin
    is_idle    = (state_q == ST_IDLE);
    win_data   = d_req && (!if_req || prefer_data);
    win_fetch  = if_req && !win_data;
    d_misalign = (d_size == 2'b11) ||
                 ((d_size == SZ_HALF) && d_addr[0]) ||
                 ((d_size == SZ_WORD) && (d_addr[1:0] != 2'b00));
  end

  // Next state, and capture of the granted request's attributes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_data) begin
          owner_d = 1'b1;
          addr_d  = d_addr;
          we_d    = d_we;
          size_d  = d_size;
          sext_d  = d_sext;
          wdata_d = d_wdata;
          err_d   = d_misalign;
          // An illegal access answers without a memory cycle.
          state_d = d_misalign ? ST_RESP : ST_ACCESS;
        end else if (win_fetch) begin
          // A fetch is always a plain aligned word read. Low address bits
          // are dropped on the memory address.
          owner_d = 1'b0;
          addr_d  = if_addr;
          we_d    = 1'b0;
          size_d  = SZ_WORD;
          sext_d  = 1'b0;
          wdata_d = 32'd0;
          err_d   = 1'b0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        cnt_d   = CNT_INIT;
        state_d = (MEM_LAT <= 1) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and transaction registers. Reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      owner_q <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
    end
  end

  // Byte enables, write-lane replication and load alignment.
  always_comb begin
    be_w       = 4'b1111;
    wdata_w    = wdata_q;
    lane_shift = mem_rdata >> {addr_q[1:0], 3'b000};
    load_w     = mem_rdata;
    unique case (size_q)
      SZ_BYTE: begin
        be_w    = 4'b0001 << addr_q[1:0];
        wdata_w = {4{wdata_q[7:0]}};
        load_w  = {{24{sext_q & lane_shift[7]}}, lane_shift[7:0]};
      end
      SZ_HALF: begin
        be_w    = 4'b0011 << {addr_q[1], 1'b0};
        wdata_w = {2{wdata_q[15:0]}};
        load_w  = {{16{sext_q & lane_shift[15]}}, lane_shift[15:0]};
      end
      default: begin
        be_w    = 4'b1111;
        wdata_w = wdata_q;
        load_w  = mem_rdata;
      end
    endcase
  end

  // Output decode. Grants are also gated by reset, because the FSM sits in
  // IDLE while reset is low.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = 32'd0;
    d_rvalid  = 1'b0;
    d_rdata   = 32'd0;
    d_err     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    busy      = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if_gnt = rst && win_fetch;
        d_gnt  = rst && win_data;
      end
      ST_ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_be    = be_w;
        mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        mem_wdata = wdata_w;
      end
      ST_RESP: begin
        if (owner_q) begin
          d_rvalid = 1'b1;
          d_err    = err_q;
          // Stores and errors return zero. Loads return the aligned lane.
          d_rdata  = (err_q || we_q) ? 32'd0 : load_w;
        end else begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. It runs directed scenarios, then randomized
// single-port traffic. Expected values come from a word-array reference
// memory and arithmetic rules for lanes, extension and errors.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [31:0]   if_rdata;
  logic          d_req = 1'b0, d_we = 1'b0, d_sext = 1'b0;
  logic [1:0]    d_size = 2'b00;
  logic [AW-1:0] d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic          d_gnt, d_rvalid, d_err;
  logic [31:0]   d_rdata;
  logic          mem_en, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic          busy;

  int passed = 0;
  int total  = 0;

  mem_port_arbiter #(.ADDR_W(AW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_sext(d_sext),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM model: byte-enabled writes. Read data appears LAT cycles after
  // mem_en and stays until the next read.
  logic [31:0] mem_arr [0:255];
  logic [31:0] pend_q = '0;
  int          rd_cnt = 0;
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem_arr[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end else if (mem_en) begin
      if (LAT == 1) mem_rdata <= mem_arr[mem_addr[9:2]];
      else begin
        pend_q <= mem_arr[mem_addr[9:2]];
        rd_cnt <= LAT - 1;
      end
    end
    if (!(mem_en && !mem_we) && rd_cnt != 0) begin
      rd_cnt <= rd_cnt - 1;
      if (rd_cnt == 1) mem_rdata <= pend_q;
    end
  end

  // Event counters sampled on each active edge.
  int men_seen = 0;
  int rv_seen  = 0;
  always @(posedge clk) begin
    if (mem_en) men_seen++;
    if (if_rvalid || d_rvalid) rv_seen++;
  end

  // Reference model state.
  logic [31:0] ref_mem [0:255];
  bit          last_d = 1'b0;   // the port served last; fetch after reset, so data wins first

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic bit model_win_data(input bit dq, input bit fq);
`ifdef ARB_RR_EN
    return dq && (!fq || !last_d);
`else
    return dq;
`endif
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 20) begin
      next_cycle();
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  // One transaction from an idle cycle through the cycle after its response.
  task automatic do_txn(input bit is_d, input bit we, input logic [1:0] size,
                        input bit sext, input logic [31:0] addr, input logic [31:0] wd);
    int nbytes, off, idx, m0, r0;
    bit err;
    logic [31:0] exp_be, exp_wd, exp_rd, w, mask;
    nbytes = (size == 2'd3) ? 4 : (1 << size);
    off    = addr % 4;
    idx    = (addr / 4) % 256;
    err    = is_d && (size == 2'd3 || (addr % nbytes) != 0);
    exp_be = is_d ? ((((1 << nbytes) - 1) << off) & 15) : 15;
    for (int k = 0; k < 4; k++) exp_wd[8*k +: 8] = wd[8*(k % nbytes) +: 8];
    w    = ref_mem[idx] >> (8 * off);
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * nbytes)) - 1);
    w    = w & mask;
    if (sext && nbytes < 4 && w[8*nbytes-1]) w = w | ~mask;
    exp_rd = !is_d ? ref_mem[idx] : ((we || err) ? 32'd0 : w);

    if (is_d) begin
      d_req = 1'b1; d_we = we; d_size = size; d_sext = sext; d_addr = addr; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    #1;
    m0 = men_seen;
    r0 = rv_seen;
    chk(is_d ? "d_gnt" : "if_gnt", is_d ? d_gnt : if_gnt, 1'b1);
    chk("other_gnt", is_d ? if_gnt : d_gnt, 1'b0);
    last_d = is_d;
    next_cycle();
    // Request inputs are don't-care after the grant, so scramble them.
    d_req = 1'b0; if_req = 1'b0;
    d_addr = $urandom; d_wdata = $urandom; d_size = 2'($urandom); d_we = 1'($urandom);
    d_sext = 1'($urandom); if_addr = $urandom;
    if (err) begin
      chk("err_rvalid", d_rvalid, 1'b1);
      chk("err_flag", d_err, 1'b1);
      chk("err_rdata", d_rdata, 32'd0);
      next_cycle();
      chk("err_no_mem_en", 32'(men_seen - m0), 32'd0);
    end else begin
      chk("mem_en", mem_en, 1'b1);
      chk("mem_we", mem_we, is_d && we);
      chk("mem_addr", mem_addr, addr & ~32'd3);
      chk("mem_be", mem_be, exp_be[3:0]);
      if (is_d && we) chk("mem_wdata", mem_wdata, exp_wd);
      repeat (LAT + 1) next_cycle();
      chk("mem_en_once", 32'(men_seen - m0), 32'd1);
      chk("no_early_rvalid", 32'(rv_seen - r0), 32'd0);
      chk(is_d ? "d_rvalid" : "if_rvalid", is_d ? d_rvalid : if_rvalid, 1'b1);
      chk("other_rvalid", is_d ? if_rvalid : d_rvalid, 1'b0);
      if (is_d) begin
        chk("d_rdata", d_rdata, exp_rd);
        chk("d_err_clear", d_err, 1'b0);
      end else begin
        chk("if_rdata", if_rdata, exp_rd);
      end
      if (is_d && we)
        for (int k = 0; k < nbytes; k++) ref_mem[idx][8*(off+k) +: 8] = wd[8*k +: 8];
      next_cycle();
    end
    chk("idle_after", busy, 1'b0);
  endtask

  // Both ports request together; the winner is dropped after its grant, and
  // the loser keeps requesting until it is granted.
  task automatic arb_round(input int n);
    bit exp_d;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_sext = 1'b0; d_addr = 32'h40 + 32'(4*n);
    if_req = 1'b1; if_addr = 32'h80 + 32'(4*n);
    #1;
    exp_d = model_win_data(1'b1, 1'b1);
    chk("tie_d_gnt", d_gnt, exp_d);
    chk("tie_if_gnt", if_gnt, !exp_d);
    last_d = exp_d;
    next_cycle();
    if (exp_d) d_req = 1'b0; else if_req = 1'b0;
    wait_idle();
    #1;
    chk("loser_gnt", exp_d ? if_gnt : d_gnt, 1'b1);
    last_d = !exp_d;
    next_cycle();
    d_req = 1'b0; if_req = 1'b0;
    wait_idle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = $urandom;
      mem_arr[i] = ref_mem[i];
    end
    ref_mem[32'h100 / 4] = 32'hE3A0_1005; mem_arr[32'h100 / 4] = 32'hE3A0_1005;
    ref_mem[32'h200 / 4] = 32'h8001_1234; mem_arr[32'h200 / 4] = 32'h8001_1234;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_be", mem_be, 4'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rvalid", {d_rvalid, if_rvalid, d_err}, 3'd0);
    chk("rst_gnt", {d_gnt, if_gnt}, 2'd0);
    rst = 1'b1;
    next_cycle();

    // Directed cases
    do_txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0);         // fetch
    do_txn(1'b1, 1'b1, 2'b00, 1'b0, 32'h203, 32'h0000_00AB); // store byte
    do_txn(1'b1, 1'b0, 2'b01, 1'b1, 32'h202, 32'd0);         // half sext
    do_txn(1'b1, 1'b0, 2'b01, 1'b0, 32'h202, 32'd0);         // half zext
    do_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h201, 32'd0);         // misaligned word
    do_txn(1'b1, 1'b0, 2'b11, 1'b0, 32'h204, 32'd0);         // reserved size
    do_txn(1'b1, 1'b1, 2'b01, 1'b0, 32'h201, 32'h1234_5678); // misaligned half store
    do_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'd0);         // reload stored word

    // Simultaneous requests
    for (int n = 0; n < 4; n++) arb_round(n);

    // Randomized single-port traffic
    for (int i = 0; i < 40; i++) begin
      do_txn($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom), 1'($urandom),
             32'($urandom_range(0, 1023)), $urandom);
    end

    // Reset in the middle of a wait
    if_req = 1'b1; if_addr = 32'h300;
    #1;
    chk("abort_gnt", if_gnt, 1'b1);
    next_cycle();
    if_req = 1'b0;
    next_cycle();
    chk("abort_busy_pre", busy, 1'b1);
    rst = 1'b0; if_req = 1'b1; d_req = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_outs", {mem_en, if_rvalid, d_rvalid, if_gnt, d_gnt}, 5'd0);
    begin
      int r0;
      r0 = rv_seen;
      repeat (3) next_cycle();
      chk("abort_no_rvalid", 32'(rv_seen - r0), 32'd0);
    end
    if_req = 1'b0; d_req = 1'b0;
    rst = 1'b1;
    last_d = 1'b0;
    next_cycle();
    do_txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
    arb_round(9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
